// File: rtl/eval_calc_pkg.sv
// Shared types and helpers for the eval_calc stream adapter and its output buffer.
package eval_calc_pkg;

   localparam int FP32_WIDTH      = 32;
   localparam int DEF_LANES       = 4;
   localparam int DEF_USER_WIDTH  = 1;
   localparam int BEAT_DATA_WIDTH = FP32_WIDTH * DEF_LANES;

   typedef struct packed {
      logic [BEAT_DATA_WIDTH-1:0] tdata;
      logic [DEF_USER_WIDTH-1:0]  tuser;
      logic                       tlast;
   } beat_t;

   // Width able to hold every value 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/eval_calc_stream_fifo.sv
// Show-ahead FIFO with a registered head; count covers memory entries plus the head register.
module eval_calc_stream_fifo
   import eval_calc_pkg::*;
#(
   parameter int WIDTH = 130,
   parameter int DEPTH = 32,
   parameter int CW    = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    mem_count;
   logic             load;
   logic             mem_pop;
   logic             mem_push;

   // The head reloads whenever it is empty or being consumed; a write into an
   // empty memory goes straight to the head so it is visible the next cycle.
   always_comb begin
      load     = !rd_valid || rd_ready;
      mem_pop  = load && (mem_count != '0);
      mem_push = wr_en && !(load && (mem_count == '0));
      count    = mem_count + CW'(rd_valid);
   end

   always_ff @(posedge clk) begin
      if (mem_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
      end else begin
         if (mem_push) wr_ptr <= wr_ptr + AW'(1);
         if (mem_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({mem_push, mem_pop})
            2'b10:   mem_count <= mem_count + CW'(1);
            2'b01:   mem_count <= mem_count - CW'(1);
            default: mem_count <= mem_count;
         endcase
         if (load) begin
            if (mem_pop) begin
               rd_data  <= mem[rd_ptr];
               rd_valid <= 1'b1;
            end else if (wr_en) begin
               rd_data  <= wr_data;
               rd_valid <= 1'b1;
            end else begin
               rd_valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) assert (!(wr_en && !(rd_valid && rd_ready) && (count == CW'(DEPTH))));
   end

endmodule

// File: rtl/eval_calc_stream_adapter.sv
// AXI4-Stream wrapper around a fixed-latency, no-backpressure elementwise calc core,
// with per-beat bypass, credit-based input flow control and beat/frame counters.
module eval_calc_stream_adapter
   import eval_calc_pkg::*;
#(
   parameter int DATA_WIDTH = FP32_WIDTH,
   parameter int LANES      = 4,
   parameter int LATENCY    = 12,
   parameter int FIFO_DEPTH = 32,
   parameter int USER_WIDTH = 1
) (
   input  logic                        aresetn,
   input  logic                        aclk,
   input  logic                        enable,
   input  logic                        bypass,
   input  logic [LANES*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [USER_WIDTH-1:0]       s_axis_tuser,
   input  logic                        s_axis_tlast,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic                        core_in_valid,
   output logic [LANES*DATA_WIDTH-1:0] core_in_data,
   input  logic [LANES*DATA_WIDTH-1:0] core_out_data,
   output logic [LANES*DATA_WIDTH-1:0] m_axis_tdata,
   output logic [USER_WIDTH-1:0]       m_axis_tuser,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        busy,
   output logic [31:0]                 beat_count,
   output logic [31:0]                 frame_count
);

   localparam int TW = LANES * DATA_WIDTH;
   localparam int BW = USER_WIDTH + 1 + TW;
   localparam int CW = count_width(FIFO_DEPTH);
   localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

   // Handshakes: a transfer happens on a rising aclk edge where valid && ready;
   // valid never waits on ready, and the source holds its payload until the transfer.
   logic                  run_q;
   logic [CW-1:0]         inflight;
   logic [CW-1:0]         fifo_count;
   logic [CW:0]           credit_used;
   logic                  accept;
   logic                  emerge;
   logic                  out_fire;
   logic [LATENCY-1:0]    dl_valid;
   logic [LATENCY-1:0]    dl_bypass;
   logic [LATENCY-1:0]    dl_last;
   logic [USER_WIDTH-1:0] dl_user [LATENCY];
   logic [TW-1:0]         dl_data [LATENCY];
   logic [BW-1:0]         fifo_wr_data;
   logic [BW-1:0]         fifo_rd_data;

   // Credit covers every beat between acceptance and output handshake, so the
   // buffer can always absorb what the delay line delivers.
   always_comb begin
      credit_used   = {1'b0, inflight} + {1'b0, fifo_count};
      s_axis_tready = run_q && enable && (credit_used < DEPTH_LIM);
      accept        = s_axis_tvalid && s_axis_tready;
      core_in_valid = accept;
      core_in_data  = run_q ? s_axis_tdata : '0;
      emerge        = dl_valid[LATENCY-1];
      fifo_wr_data  = {dl_user[LATENCY-1], dl_last[LATENCY-1],
                       dl_bypass[LATENCY-1] ? dl_data[LATENCY-1] : core_out_data};
      {m_axis_tuser, m_axis_tlast, m_axis_tdata} = fifo_rd_data;
      out_fire      = m_axis_tvalid && m_axis_tready;
      busy          = (inflight != '0) || (fifo_count != '0) || m_axis_tvalid;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         run_q       <= 1'b0;
         inflight    <= '0;
         dl_valid    <= '0;
         dl_bypass   <= '0;
         dl_last     <= '0;
         beat_count  <= '0;
         frame_count <= '0;
      end else begin
         run_q       <= 1'b1;
         dl_valid[0]  <= accept;
         dl_bypass[0] <= bypass;
         dl_last[0]   <= s_axis_tlast;
         for (int i = 1; i < LATENCY; i++) begin
            dl_valid[i]  <= dl_valid[i-1];
            dl_bypass[i] <= dl_bypass[i-1];
            dl_last[i]   <= dl_last[i-1];
         end
         case ({accept, emerge})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
         if (out_fire) begin
            beat_count <= beat_count + 32'd1;
            if (m_axis_tlast) frame_count <= frame_count + 32'd1;
         end
      end
   end

   // Payload stages need no reset: nothing downstream looks at them without dl_valid.
   always_ff @(posedge aclk) begin
      dl_user[0] <= s_axis_tuser;
      dl_data[0] <= bypass ? s_axis_tdata : '0;
      for (int i = 1; i < LATENCY; i++) begin
         dl_user[i] <= dl_user[i-1];
         dl_data[i] <= dl_data[i-1];
      end
   end

   eval_calc_stream_fifo #(
      .WIDTH (BW),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk      (aclk),
      .rst_n    (aresetn),
      .wr_en    (emerge),
      .wr_data  (fifo_wr_data),
      .rd_data  (fifo_rd_data),
      .rd_valid (m_axis_tvalid),
      .rd_ready (m_axis_tready),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_eval_calc_stream_adapter.sv
// Bench for eval_calc_stream_adapter: table vectors, directed corner sequences and
// random traffic checked against a queue-based model of the stream.
module tb_eval_calc_stream_adapter;

   localparam int DW    = 32;
   localparam int LN    = 4;
   localparam int LAT   = 12;
   localparam int DEPTH = 32;
   localparam int UW    = 1;
   localparam int TW    = DW * LN;
   localparam int EW    = UW + 1 + TW;
   localparam int NV    = 6;

   logic          aclk;
   logic          aresetn;
   logic          enable;
   logic          bypass;
   logic [TW-1:0] s_axis_tdata;
   logic [UW-1:0] s_axis_tuser;
   logic          s_axis_tlast;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          core_in_valid;
   logic [TW-1:0] core_in_data;
   logic [TW-1:0] core_out_data;
   logic [TW-1:0] m_axis_tdata;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          busy;
   logic [31:0]   beat_count;
   logic [31:0]   frame_count;

   eval_calc_stream_adapter #(
      .DATA_WIDTH (DW),
      .LANES      (LN),
      .LATENCY    (LAT),
      .FIFO_DEPTH (DEPTH),
      .USER_WIDTH (UW)
   ) dut (
      .aresetn       (aresetn),
      .aclk          (aclk),
      .enable        (enable),
      .bypass        (bypass),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .core_in_valid (core_in_valid),
      .core_in_data  (core_in_data),
      .core_out_data (core_out_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .beat_count    (beat_count),
      .frame_count   (frame_count)
   );

   // ---------------- clock / reset ----------------
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [TW-1:0] plus_one(input logic [TW-1:0] d);
      logic [TW-1:0] r;
      for (int k = 0; k < LN; k++) r[k*DW +: DW] = d[k*DW +: DW] + 32'd1;
      return r;
   endfunction

   function automatic logic [TW-1:0] rnd_data();
      logic [TW-1:0] r;
      for (int k = 0; k < LN; k++) r[k*DW +: DW] = $urandom;
      return r;
   endfunction

   // Core model: elementwise x+1, exactly LAT cycles, no backpressure.
   logic [TW-1:0] core_pipe [LAT];
   always @(posedge aclk) begin
      core_pipe[0] <= plus_one(core_in_data);
      for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign core_out_data = core_pipe[LAT-1];

   // ---------------- scoreboard / monitor ----------------
   logic [EW-1:0] exp_q[$];
   int            in_cyc[$];
   int            out_cyc[$];
   logic [31:0]   mdl_beats  = '0;
   logic [31:0]   mdl_frames = '0;
   int            mon_cyc    = 0;
   int            max_occ    = 0;
   bit            stall_seen = 0;
   bit            chk_credit = 0;
   bit            hold_valid = 0;
   logic [EW-1:0] hold_beat;

   always @(negedge aclk) begin
      logic [EW-1:0] e;
      mon_cyc++;
      if (!aresetn) begin
         exp_q.delete();
         mdl_beats  = '0;
         mdl_frames = '0;
         hold_valid = 0;
      end else begin
         if (chk_credit)
            check("s_tready_credit", s_axis_tready, enable && (exp_q.size() < DEPTH));
         check("busy", busy, exp_q.size() != 0);
         check("beat_count", beat_count, mdl_beats);
         check("frame_count", frame_count, mdl_frames);
         check("core_in_valid", core_in_valid, s_axis_tvalid && s_axis_tready);
         if (hold_valid)
            check("out_hold_stable", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                  {1'b1, hold_beat});
         if (enable && s_axis_tvalid && !s_axis_tready && chk_credit) stall_seen = 1;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("out_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, e);
            end
            out_cyc.push_back(mon_cyc);
            mdl_beats++;
            if (m_axis_tlast) mdl_frames++;
         end
         if (s_axis_tvalid && s_axis_tready) begin
            check("core_in_data", core_in_data, s_axis_tdata);
            exp_q.push_back({s_axis_tuser, s_axis_tlast,
                             bypass ? s_axis_tdata : plus_one(s_axis_tdata)});
            in_cyc.push_back(mon_cyc);
         end
         if (exp_q.size() > max_occ) max_occ = exp_q.size();
         hold_valid = m_axis_tvalid && !m_axis_tready;
         hold_beat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_beat(input logic [TW-1:0] d, input logic b, input logic [UW-1:0] u,
                            input logic l);
      bit ok;
      int n;
      s_axis_tdata  = d;
      bypass        = b;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      ok = 0;
      n  = 0;
      while (!ok) begin
         @(negedge aclk);
         ok = s_axis_tready;
         step();
         n++;
         if (!ok && n >= 2000) begin
            check("send_timeout", ok, 1'b1);
            break;
         end
      end
   endtask

   task automatic send_frame(input int n, input bit rand_byp);
      for (int i = 0; i < n; i++)
         send_beat(rnd_data(), rand_byp ? 1'($urandom_range(0, 1)) : 1'b0,
                   UW'($urandom_range(0, 1)), i == n - 1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (1) begin
         @(negedge aclk);
         if (!busy && exp_q.size() == 0) break;
         n++;
         if (n >= 1000) begin
            check("drain_timeout", busy, 1'b0);
            break;
         end
      end
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_tready"}, s_axis_tready, 1'b0);
      check({tag, "_core_in_valid"}, core_in_valid, 1'b0);
      check({tag, "_core_in_data"}, core_in_data, '0);
      check({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
      check({tag, "_m_beat"}, {m_axis_tuser, m_axis_tlast, m_axis_tdata}, '0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_counts"}, {beat_count, frame_count}, 64'd0);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [TW-1:0] data;
      logic          byp;
      logic [UW-1:0] user;
      logic          last;
      logic [TW-1:0] exp;
   } vec_t;

   vec_t vecs [NV];

   // ---------------- test sequence ----------------
   initial begin
      int lat;
      int nlast;
      int b0;
      int f0;
      bit got;
      bit rnd_done;

      vecs[0] = '{data: {32'd4, 32'd3, 32'd2, 32'd1}, byp: 1'b0, user: 1'b0, last: 1'b1,
                  exp:  {32'd5, 32'd4, 32'd3, 32'd2}};
      vecs[1] = '{data: {4{32'hFFFF_FFFF}}, byp: 1'b0, user: 1'b1, last: 1'b0,
                  exp:  {4{32'h0000_0000}}};
      vecs[2] = '{data: {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_FFFF},
                  byp: 1'b1, user: 1'b0, last: 1'b1,
                  exp: {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_FFFF}};
      vecs[3] = '{data: {4{32'h3F80_0000}}, byp: 1'b0, user: 1'b1, last: 1'b0,
                  exp:  {4{32'h3F80_0001}}};
      vecs[4] = '{data: {4{32'h0000_0000}}, byp: 1'b1, user: 1'b1, last: 1'b1,
                  exp:  {4{32'h0000_0000}}};
      vecs[5] = '{data: {32'h7FFF_FFFF, 32'h0000_00FF, 32'h8000_0000, 32'h0000_0010},
                  byp: 1'b0, user: 1'b0, last: 1'b1,
                  exp: {32'h8000_0000, 32'h0000_0100, 32'h8000_0001, 32'h0000_0011}};

      // Reset state, with inputs active so gating is exercised.
      aresetn       = 1'b0;
      enable        = 1'b1;
      bypass        = 1'b0;
      s_axis_tdata  = {4{32'hA5A5_A5A5}};
      s_axis_tuser  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
      #1;
      check_reset_outputs("reset");
      repeat (3) step();
      s_axis_tvalid = 1'b0;
      aresetn = 1'b1;
      repeat (2) step();
      chk_credit = 1;

      // Table vectors: single beats into an empty pipe.
      nlast = 0;
      for (int v = 0; v < NV; v++) begin
         send_beat(vecs[v].data, vecs[v].byp, vecs[v].user, vecs[v].last);
         s_axis_tvalid = 1'b0;
         nlast += int'(vecs[v].last);
         lat = 1;
         got = 0;
         while (!got && lat <= 50) begin
            @(negedge aclk);
            if (m_axis_tvalid) got = 1;
            else begin
               lat++;
               step();
            end
         end
         check("vec_latency", lat, LAT + 1);
         check("vec_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata},
               {vecs[v].user, vecs[v].last, vecs[v].exp});
         step();
         wait_idle();
         if (v == 0) check("first_frame_count", frame_count, 32'd1);
      end
      check("table_beats", beat_count, NV);
      check("table_frames", frame_count, nlast);

      // 100-beat frame at full rate.
      b0 = beat_count;
      f0 = frame_count;
      out_cyc.delete();
      send_frame(100, 1'b1);
      wait_idle();
      check("frame_out_beats", out_cyc.size(), 100);
      if (out_cyc.size() == 100) check("frame_no_gap", out_cyc[99] - out_cyc[0], 99);
      check("frame_beat_delta", beat_count - b0, 100);
      check("frame_frame_delta", frame_count - f0, 1);

      // Same frame with 40 cycles of output backpressure.
      max_occ    = 0;
      stall_seen = 0;
      fork
         begin
            m_axis_tready = 1'b0;
            repeat (40) step();
            m_axis_tready = 1'b1;
         end
         send_frame(100, 1'b1);
      join
      wait_idle();
      check("bp_peak_occupancy", max_occ, DEPTH);
      check("bp_input_stalled", stall_seen, 1'b1);

      // Alternating bypass: identical latency for both modes.
      in_cyc.delete();
      out_cyc.delete();
      for (int i = 0; i < 8; i++) send_beat({LN{DW'(i + 10)}}, 1'(i % 2), '0, i == 7);
      s_axis_tvalid = 1'b0;
      wait_idle();
      check("alt_count", {in_cyc.size(), out_cyc.size()}, {32'd8, 32'd8});
      for (int k = 0; k < 8 && k < in_cyc.size() && k < out_cyc.size(); k++)
         check("alt_latency", out_cyc[k] - in_cyc[k], LAT + 1);

      // Enable low for 20 cycles mid-frame.
      for (int i = 0; i < 5; i++) send_beat(rnd_data(), 1'b0, '0, 1'b0);
      s_axis_tdata = rnd_data();
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         check("enable_low_tready", s_axis_tready, 1'b0);
         step();
      end
      @(negedge aclk);
      check("enable_low_drained", busy, 1'b0);
      step();
      enable = 1'b1;
      for (int i = 0; i < 5; i++) send_beat(rnd_data(), 1'(i % 2), '1, i == 4);
      s_axis_tvalid = 1'b0;
      wait_idle();

      // Reset with 10 beats in flight.
      for (int i = 0; i < 10; i++) send_beat(rnd_data(), 1'(i % 2), '0, i == 9);
      s_axis_tvalid = 1'b1;
      chk_credit = 0;
      #3;
      aresetn = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (3) step();
      s_axis_tvalid = 1'b0;
      aresetn = 1'b1;
      repeat (2) step();
      chk_credit = 1;
      send_frame(3, 1'b1);
      wait_idle();
      check("post_reset_frames", frame_count, 32'd1);
      check("post_reset_beats", beat_count, 32'd3);

      // Random traffic with random backpressure and input gaps.
      rnd_done = 0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  s_axis_tvalid = 1'b0;
                  enable = 1'($urandom_range(0, 1));
                  repeat ($urandom_range(1, 4)) step();
                  enable = 1'b1;
               end
               send_beat(rnd_data(), 1'($urandom_range(0, 1)), UW'($urandom_range(0, 1)),
                         $urandom_range(0, 7) == 0);
            end
            s_axis_tvalid = 1'b0;
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               m_axis_tready = ($urandom_range(0, 3) != 0);
               step();
            end
            m_axis_tready = 1'b1;
         end
      join
      wait_idle();
      check("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
